// File: rtl/frame_uart_packer_if.sv
// Camera-side strobes, UART TX handshake and packer status grouped into one bundle.
//   frame_start/frame_end/data_valid/data_in : camera byte stream into the packer
//   tx_start/tx_data/tx_finish                 : one-byte UART send handshake
//   busy/overflow/aborted/frame_bytes          : packer status
// The slave modport is the packer; the master modport is its environment.
interface frame_uart_packer_if;
    logic        frame_start;
    logic        frame_end;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_finish;
    logic        busy;
    logic        overflow;
    logic        aborted;
    logic [15:0] frame_bytes;

    modport master (
        output frame_start, frame_end, data_valid, data_in, tx_finish,
        input  tx_start, tx_data, busy, overflow, aborted, frame_bytes
    );

    modport slave (
        input  frame_start, frame_end, data_valid, data_in, tx_finish,
        output tx_start, tx_data, busy, overflow, aborted, frame_bytes
    );
endinterface

// File: rtl/frame_uart_packer.sv
// Buffers camera bytes in a FIFO and emits each frame as
// SYNC0, SYNC1, payload..., checksum, TRAILER over a byte-wide UART handshake.
//   sys_clk : system clock
//   rst     : synchronous active-high reset
//   link    : slave side of frame_uart_packer_if (camera in, UART out, status)
module frame_uart_packer #(
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned DECIM      = 1,
    parameter logic [7:0]  SYNC0      = 8'hA5,
    parameter logic [7:0]  SYNC1      = 8'h5A,
    parameter logic [7:0]  TRAILER    = 8'h0D
) (
    input  logic               sys_clk,
    input  logic               rst,
    frame_uart_packer_if.slave link
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CSUM,
        ST_TRAILER
    } state_t;

    // ---------------- input side: frame tracking, decimation, FIFO ----------------
    logic          frame_active;
    logic [DW-1:0] dec_cnt;
    logic [7:0]    csum;
    logic [15:0]   frame_bytes;
    logic          overflow;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop_c;

    logic          take_c;
    logic [DW-1:0] dec_base_c;
    logic          cand_c;
    logic          full_c;
    logic          wr_c;
    logic          drop_c;

    // A frame_start restarts decimation, so a byte arriving with it sees count 0.
    assign take_c     = link.data_valid & (link.frame_start | frame_active);
    assign dec_base_c = link.frame_start ? '0 : dec_cnt;
    assign cand_c     = take_c & (dec_base_c == '0);
    assign full_c     = (count == CW'(FIFO_DEPTH));
    // Fullness is judged before any same-cycle pop; frame_start flushes, so it always has room.
    assign wr_c       = cand_c & (link.frame_start | !full_c);
    assign drop_c     = cand_c & !wr_c;

    // Frame flag, decimation counter, checksum, byte count and overflow flag.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            frame_active <= 1'b0;
            dec_cnt      <= '0;
            csum         <= '0;
            frame_bytes  <= '0;
            overflow     <= 1'b0;
        end else begin
            if (link.frame_start) begin
                frame_active <= 1'b1;
            end else if (link.frame_end) begin
                frame_active <= 1'b0;
            end

            if (take_c) begin
                dec_cnt <= (dec_base_c == DW'(DECIM - 1)) ? '0 : dec_base_c + DW'(1);
            end else if (link.frame_start) begin
                dec_cnt <= '0;
            end

            if (link.frame_start) begin
                csum        <= wr_c ? link.data_in : 8'h00;
                frame_bytes <= wr_c ? 16'h0001 : 16'h0000;
                overflow    <= drop_c;
            end else begin
                if (wr_c) begin
                    csum <= csum + link.data_in;
                    if (frame_bytes != 16'hFFFF) begin
                        frame_bytes <= frame_bytes + 16'h0001;
                    end
                end
                if (drop_c) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers; frame_start discards whatever the previous frame left behind.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (link.frame_start) begin
            rd_ptr <= wr_ptr;
            wr_ptr <= wr_ptr + AW'(wr_c);
            count  <= CW'(wr_c);
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_c);
            rd_ptr <= rd_ptr + AW'(pop_c);
            count  <= count + CW'(wr_c) - CW'(pop_c);
        end
    end

    // FIFO storage, not reset.
    always_ff @(posedge sys_clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= link.data_in;
        end
    end

    // ---------------- output side: packet FSM and byte handshake ----------------
    state_t     state_q, state_n;
    logic       tx_start_q, tx_start_n;
    logic [7:0] tx_data_q, tx_data_n;
    logic       wait_hi_q, wait_hi_n;
    logic       pend_q, pend_n;
    logic       aborted_q, aborted_n;
    logic       busy_q, busy_n;
    logic       launch;
    logic [7:0] launch_byte;

    logic       byte_done_c;
    logic       slot_free_c;

    // A byte completes when tx_finish returns high after having been seen low.
    assign byte_done_c = wait_hi_q & link.tx_finish;
    assign slot_free_c = !(tx_start_q | wait_hi_q) | byte_done_c;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            wait_hi_q  <= 1'b0;
            pend_q     <= 1'b0;
            aborted_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            tx_start_q <= tx_start_n;
            tx_data_q  <= tx_data_n;
            wait_hi_q  <= wait_hi_n;
            pend_q     <= pend_n;
            aborted_q  <= aborted_n;
            busy_q     <= busy_n;
        end
    end

    // Next state, byte launches and FIFO pops.
    always_comb begin
        state_n     = state_q;
        tx_start_n  = tx_start_q;
        tx_data_n   = tx_data_q;
        wait_hi_n   = wait_hi_q;
        pend_n      = pend_q;
        aborted_n   = aborted_q;
        pop_c       = 1'b0;
        launch      = 1'b0;
        launch_byte = 8'h00;

        if (tx_start_q && !link.tx_finish) begin
            tx_start_n = 1'b0;
            wait_hi_n  = 1'b1;
        end
        if (byte_done_c) begin
            wait_hi_n = 1'b0;
        end

        if (link.frame_start && (state_q != ST_IDLE)) begin
            // Abort: let the byte in flight finish, then restart at the header.
            aborted_n = 1'b1;
            if (slot_free_c) begin
                state_n     = ST_HDR0;
                launch      = 1'b1;
                launch_byte = SYNC0;
                pend_n      = 1'b0;
            end else begin
                pend_n = 1'b1;
            end
        end else if (pend_q) begin
            if (slot_free_c) begin
                state_n     = ST_HDR0;
                launch      = 1'b1;
                launch_byte = SYNC0;
                pend_n      = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (link.frame_start) begin
                        state_n     = ST_HDR0;
                        launch      = 1'b1;
                        launch_byte = SYNC0;
                    end
                end
                ST_HDR0: begin
                    if (byte_done_c) begin
                        state_n     = ST_HDR1;
                        launch      = 1'b1;
                        launch_byte = SYNC1;
                    end
                end
                ST_HDR1: begin
                    if (byte_done_c) begin
                        state_n = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (slot_free_c) begin
                        if (count != '0) begin
                            pop_c       = 1'b1;
                            launch      = 1'b1;
                            launch_byte = mem[rd_ptr];
                        end else if (!frame_active) begin
                            state_n     = ST_CSUM;
                            launch      = 1'b1;
                            launch_byte = csum;
                        end
                    end
                end
                ST_CSUM: begin
                    if (byte_done_c) begin
                        state_n     = ST_TRAILER;
                        launch      = 1'b1;
                        launch_byte = TRAILER;
                    end
                end
                ST_TRAILER: begin
                    if (byte_done_c) begin
                        state_n   = ST_IDLE;
                        aborted_n = 1'b0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        if (launch) begin
            tx_start_n = 1'b1;
            tx_data_n  = launch_byte;
        end
    end

    assign busy_n = (state_n != ST_IDLE);

    assign link.tx_start    = tx_start_q;
    assign link.tx_data     = tx_data_q;
    assign link.busy        = busy_q;
    assign link.aborted     = aborted_q;
    assign link.overflow    = overflow;
    assign link.frame_bytes = frame_bytes;

endmodule

// File: tb/tb_frame_uart_packer.sv
// Scoreboard bench: expected UART bytes are queued as stimulus is driven; a UART
// model per DUT records each byte it accepts, and the test tasks compare the two.
// dut_a: FIFO_DEPTH=4, DECIM=1.  dut_b: FIFO_DEPTH=16, DECIM=2.
module tb_frame_uart_packer;

    logic sys_clk;
    logic rst;

    frame_uart_packer_if ifa ();
    frame_uart_packer_if ifb ();

    frame_uart_packer #(.FIFO_DEPTH(4), .DECIM(1)) dut_a (
        .sys_clk (sys_clk),
        .rst     (rst),
        .link    (ifa)
    );

    frame_uart_packer #(.FIFO_DEPTH(16), .DECIM(2)) dut_b (
        .sys_clk (sys_clk),
        .rst     (rst),
        .link    (ifb)
    );

    int total  = 0;
    int passed = 0;

    logic [7:0] exp_a[$];
    logic [7:0] obs_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] obs_b[$];
    int         proto_err_a = 0;
    int         proto_err_b = 0;
    bit         stall_a = 1'b0;
    logic [7:0] held_a;
    logic [7:0] held_b;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // UART model A: lowers tx_finish 2 cycles after a start, raises it 20 cycles later.
    initial begin
        ifa.tx_finish = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (ifa.tx_start === 1'b1 && !stall_a) begin
                held_a = ifa.tx_data;
                obs_a.push_back(held_a);
                repeat (2) begin
                    @(negedge sys_clk);
                    if (ifa.tx_start !== 1'b1 || ifa.tx_data !== held_a) proto_err_a++;
                end
                ifa.tx_finish = 1'b0;
                @(negedge sys_clk);
                if (ifa.tx_start !== 1'b0) proto_err_a++;
                repeat (19) @(negedge sys_clk);
                ifa.tx_finish = 1'b1;
            end
        end
    end

    // UART model B, same timing.
    initial begin
        ifb.tx_finish = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (ifb.tx_start === 1'b1) begin
                held_b = ifb.tx_data;
                obs_b.push_back(held_b);
                repeat (2) begin
                    @(negedge sys_clk);
                    if (ifb.tx_start !== 1'b1 || ifb.tx_data !== held_b) proto_err_b++;
                end
                ifb.tx_finish = 1'b0;
                @(negedge sys_clk);
                if (ifb.tx_start !== 1'b0) proto_err_b++;
                repeat (19) @(negedge sys_clk);
                ifb.tx_finish = 1'b1;
            end
        end
    end

    // One-cycle input pulse on A, starting at a negedge.
    task automatic drive_a(input bit fs, input bit fe, input bit dv, input logic [7:0] d);
        ifa.frame_start = fs;
        ifa.frame_end   = fe;
        ifa.data_valid  = dv;
        ifa.data_in     = d;
        @(negedge sys_clk);
        ifa.frame_start = 1'b0;
        ifa.frame_end   = 1'b0;
        ifa.data_valid  = 1'b0;
        ifa.data_in     = 8'h00;
    endtask

    task automatic drive_b(input bit fs, input bit fe, input bit dv, input logic [7:0] d);
        ifb.frame_start = fs;
        ifb.frame_end   = fe;
        ifb.data_valid  = dv;
        ifb.data_in     = d;
        @(negedge sys_clk);
        ifb.frame_start = 1'b0;
        ifb.frame_end   = 1'b0;
        ifb.data_valid  = 1'b0;
        ifb.data_in     = 8'h00;
    endtask

    task automatic wait_obs_a(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (obs_a.size() >= n) break;
            @(negedge sys_clk);
        end
        if (obs_a.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_idle_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (ifa.busy === 1'b0) break;
            @(negedge sys_clk);
        end
        if (ifa.busy === 1'b0) ok = 1'b1;
    endtask

    task automatic wait_idle_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (ifb.busy === 1'b0) break;
            @(negedge sys_clk);
        end
        if (ifb.busy === 1'b0) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        total++; if (ifa.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", ifa.tx_start); else passed++;
        total++; if (ifa.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", ifa.tx_data); else passed++;
        total++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifa.busy); else passed++;
        total++; if (ifa.overflow !== 1'b0 || ifa.aborted !== 1'b0) $display("FAIL reset_flags: got ovf=%b abt=%b want 0 0", ifa.overflow, ifa.aborted); else passed++;
        total++; if (ifa.frame_bytes !== 16'h0000) $display("FAIL reset_frame_bytes: got %h want 0000", ifa.frame_bytes); else passed++;
        total++; if (ifb.busy !== 1'b0 || ifb.tx_start !== 1'b0) $display("FAIL reset_b: got busy=%b start=%b want 0 0", ifb.busy, ifb.tx_start); else passed++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] e, o;
        exp_a = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h06, 8'h0D};
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (ifa.tx_start !== 1'b1 || ifa.tx_data !== 8'hA5) $display("FAIL basic_latency: got start=%b data=%h want 1 a5", ifa.tx_start, ifa.tx_data); else passed++;
        drive_a(1'b0, 1'b0, 1'b1, 8'h01);
        drive_a(1'b0, 1'b0, 1'b1, 8'h02);
        drive_a(1'b0, 1'b1, 1'b1, 8'h03);
        wait_obs_a(7, ok);
        total++; if (!ok) $display("FAIL basic_timeout: got %0d bytes want 7", obs_a.size()); else passed++;
        total++; if (ifa.busy !== 1'b1) $display("FAIL basic_busy_during_trailer: got %b want 1", ifa.busy); else passed++;
        wait_idle_a(ok);
        total++; if (!ok) $display("FAIL basic_idle_timeout: busy stuck at %b want 0", ifa.busy); else passed++;
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() > 0) ? obs_a.pop_front() : 8'hxx;
            total++; if (o !== e) $display("FAIL basic_byte: got %h want %h", o, e); else passed++;
        end
        total++; if (obs_a.size() != 0) $display("FAIL basic_extra_bytes: got %0d want 0", obs_a.size()); else passed++;
        total++; if (ifa.frame_bytes !== 16'd3) $display("FAIL basic_frame_bytes: got %0d want 3", ifa.frame_bytes); else passed++;
        total++; if (ifa.overflow !== 1'b0) $display("FAIL basic_overflow: got %b want 0", ifa.overflow); else passed++;
        total++; if (proto_err_a != 0) $display("FAIL basic_handshake: got %0d errors want 0", proto_err_a); else passed++;
    endtask

    task automatic test_decim();
        bit ok;
        logic [7:0] e, o;
        exp_b = '{8'hA5, 8'h5A, 8'h10, 8'h12, 8'h14, 8'h36, 8'h0D};
        // First byte arrives together with frame_start and belongs to the new frame.
        drive_b(1'b1, 1'b0, 1'b1, 8'h10);
        for (int i = 1; i < 5; i++) drive_b(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
        drive_b(1'b0, 1'b1, 1'b1, 8'h15);
        total++; if (ifb.frame_bytes !== 16'd3) $display("FAIL decim_frame_bytes: got %0d want 3", ifb.frame_bytes); else passed++;
        wait_idle_b(ok);
        total++; if (!ok) $display("FAIL decim_idle_timeout: busy stuck at %b want 0", ifb.busy); else passed++;
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            o = (obs_b.size() > 0) ? obs_b.pop_front() : 8'hxx;
            total++; if (o !== e) $display("FAIL decim_byte: got %h want %h", o, e); else passed++;
        end
        total++; if (obs_b.size() != 0) $display("FAIL decim_extra_bytes: got %0d want 0", obs_b.size()); else passed++;
        total++; if (proto_err_b != 0) $display("FAIL decim_handshake: got %0d errors want 0", proto_err_b); else passed++;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] e, o;
        logic [7:0] sum;
        stall_a = 1'b1;
        sum = 8'h00;
        exp_a = '{8'hA5, 8'h5A};
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                exp_a.push_back(8'h21 + 8'(i));
                sum = sum + 8'h21 + 8'(i);
            end
            drive_a(1'b0, (i == 9), 1'b1, 8'h21 + 8'(i));
        end
        exp_a.push_back(sum);
        exp_a.push_back(8'h0D);
        total++; if (ifa.overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ifa.overflow); else passed++;
        total++; if (ifa.frame_bytes !== 16'd4) $display("FAIL ovf_frame_bytes: got %0d want 4", ifa.frame_bytes); else passed++;
        total++; if (ifa.tx_start !== 1'b1 || ifa.tx_data !== 8'hA5) $display("FAIL ovf_header_held: got start=%b data=%h want 1 a5", ifa.tx_start, ifa.tx_data); else passed++;
        stall_a = 1'b0;
        wait_idle_a(ok);
        total++; if (!ok) $display("FAIL ovf_idle_timeout: busy stuck at %b want 0", ifa.busy); else passed++;
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() > 0) ? obs_a.pop_front() : 8'hxx;
            total++; if (o !== e) $display("FAIL ovf_byte: got %h want %h", o, e); else passed++;
        end
        total++; if (obs_a.size() != 0) $display("FAIL ovf_extra_bytes: got %0d want 0", obs_a.size()); else passed++;
    endtask

    task automatic test_abort();
        bit ok;
        logic [7:0] e, o;
        exp_a = '{8'hA5, 8'h5A, 8'h31, 8'hA5, 8'h5A, 8'h41, 8'h41, 8'h0D};
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        drive_a(1'b0, 1'b0, 1'b1, 8'h31);
        drive_a(1'b0, 1'b0, 1'b1, 8'h32);
        drive_a(1'b0, 1'b0, 1'b1, 8'h33);
        wait_obs_a(3, ok);
        total++; if (!ok) $display("FAIL abort_first_payload_timeout: got %0d bytes want 3", obs_a.size()); else passed++;
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (ifa.aborted !== 1'b1) $display("FAIL abort_flag_set: got %b want 1", ifa.aborted); else passed++;
        drive_a(1'b0, 1'b1, 1'b1, 8'h41);
        total++; if (ifa.frame_bytes !== 16'd1) $display("FAIL abort_frame_bytes: got %0d want 1", ifa.frame_bytes); else passed++;
        wait_obs_a(8, ok);
        total++; if (ifa.aborted !== 1'b1) $display("FAIL abort_flag_held: got %b want 1", ifa.aborted); else passed++;
        wait_idle_a(ok);
        total++; if (!ok) $display("FAIL abort_idle_timeout: busy stuck at %b want 0", ifa.busy); else passed++;
        total++; if (ifa.aborted !== 1'b0) $display("FAIL abort_flag_cleared: got %b want 0", ifa.aborted); else passed++;
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() > 0) ? obs_a.pop_front() : 8'hxx;
            total++; if (o !== e) $display("FAIL abort_byte: got %h want %h", o, e); else passed++;
        end
        total++; if (obs_a.size() != 0) $display("FAIL abort_extra_bytes: got %0d want 0", obs_a.size()); else passed++;
        total++; if (proto_err_a != 0) $display("FAIL abort_handshake: got %0d errors want 0", proto_err_a); else passed++;
    endtask

    task automatic test_empty_frame();
        bit ok;
        logic [7:0] e, o;
        exp_a = '{8'hA5, 8'h5A, 8'h00, 8'h0D};
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00);
        wait_idle_a(ok);
        total++; if (!ok) $display("FAIL empty_idle_timeout: busy stuck at %b want 0", ifa.busy); else passed++;
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() > 0) ? obs_a.pop_front() : 8'hxx;
            total++; if (o !== e) $display("FAIL empty_byte: got %h want %h", o, e); else passed++;
        end
        total++; if (obs_a.size() != 0) $display("FAIL empty_extra_bytes: got %0d want 0", obs_a.size()); else passed++;
        total++; if (ifa.frame_bytes !== 16'd0 || ifa.overflow !== 1'b0) $display("FAIL empty_status: got bytes=%0d ovf=%b want 0 0", ifa.frame_bytes, ifa.overflow); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] e, o;
        drive_a(1'b1, 1'b0, 1'b1, 8'h99);
        total++; if (ifa.tx_start !== 1'b1) $display("FAIL rstmid_start_before: got %b want 1", ifa.tx_start); else passed++;
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        total++; if (ifa.tx_start !== 1'b0 || ifa.busy !== 1'b0) $display("FAIL rstmid_outputs: got start=%b busy=%b want 0 0", ifa.tx_start, ifa.busy); else passed++;
        total++; if (ifa.frame_bytes !== 16'd0) $display("FAIL rstmid_frame_bytes: got %0d want 0", ifa.frame_bytes); else passed++;
        repeat (30) @(negedge sys_clk);
        obs_a.delete();
        proto_err_a = 0;
        // No frame is active after reset, so this byte must be ignored.
        drive_a(1'b0, 1'b0, 1'b1, 8'h55);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge sys_clk);
        total++; if (ifa.frame_bytes !== 16'd0 || ifa.busy !== 1'b0 || obs_a.size() != 0) $display("FAIL rstmid_ignored: got bytes=%0d busy=%b sent=%0d want 0 0 0", ifa.frame_bytes, ifa.busy, obs_a.size()); else passed++;
        exp_a = '{8'hA5, 8'h5A, 8'h77, 8'h77, 8'h0D};
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        drive_a(1'b0, 1'b1, 1'b1, 8'h77);
        wait_idle_a(ok);
        total++; if (!ok) $display("FAIL rstmid_idle_timeout: busy stuck at %b want 0", ifa.busy); else passed++;
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() > 0) ? obs_a.pop_front() : 8'hxx;
            total++; if (o !== e) $display("FAIL rstmid_byte: got %h want %h", o, e); else passed++;
        end
        total++; if (obs_a.size() != 0) $display("FAIL rstmid_extra_bytes: got %0d want 0", obs_a.size()); else passed++;
        total++; if (proto_err_a != 0) $display("FAIL rstmid_handshake: got %0d errors want 0", proto_err_a); else passed++;
    endtask

    initial begin
        rst             = 1'b1;
        ifa.frame_start = 1'b0;
        ifa.frame_end   = 1'b0;
        ifa.data_valid  = 1'b0;
        ifa.data_in     = 8'h00;
        ifb.frame_start = 1'b0;
        ifb.frame_end   = 1'b0;
        ifb.data_valid  = 1'b0;
        ifb.data_in     = 8'h00;
        @(negedge sys_clk);

        test_reset();
        test_basic();
        test_decim();
        test_overflow();
        test_abort();
        test_empty_frame();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
